io_uart_port_ctrl: RTL and testbench
====================================

// Module: io_uart_port_ctrl
// PURPOSE
//  Processor-side IO port controller between processor_top's IO bus (IO_port_ID/IO_*_strobe) and the UART TX/RX cores.
//  Decodes port IDs and buffers outgoing bytes in a TX FIFO drained via valid/ready handshake.
//  Holds one received byte and exposes RX-present / TX-full status ports polled by firmware.
// PARAMETERS
//  TX_DEPTH     8      TX FIFO entries; power of two, >=2
//  PORT_DATA    8'h01  write: push TX FIFO; read: RX data (pops holding reg)
//  PORT_RXSTAT  8'h02  read: 8'hFF if RX byte present else 8'h00
//  PORT_TXSTAT  8'h03  read: 8'hFF if TX FIFO full else 8'h00
//  PORT_OVR     8'h04  read: overrun status (IO_RX_OVERRUN_EN only)
// PORTS
//  clk100           in   1  system clock, all state on rising edge
//  reset_n          in   1  asynchronous, active-low reset
//  IO_port_ID       in   8  port address from processor
//  IO_write_data    in   8  write data from processor
//  IO_write_strobe  in   1  processor IO write request
//  IO_read_strobe   in   1  processor IO read request
//  IO_read_data     out  8  read data to processor
//  tx_data          out  8  byte to UART transmitter (FIFO head)
//  tx_valid         out  1  tx_data valid
//  tx_ready         in   1  transmitter accepts byte this cycle
//  rx_data          in   8  byte from UART receiver
//  rx_valid         in   1  one-cycle pulse: rx_data valid
// BEHAVIOUR
//  Reset: FIFO empty (rd/wr ptr, count = 0), tx_valid=0, tx_data=0, rx holding empty, rx reg=0, strobe history=0, overrun=0.
//  Strobe qualify: action only on cycle strobe rises (strobe=1, registered prev=0); held strobe does not repeat push/pop.
//  IO_read_data: combinational from IO_port_ID (valid whenever strobe high): DATA->rx reg, RXSTAT/TXSTAT per above,
//   any other ID -> 8'hFF. Reading RXSTAT/TXSTAT has no side effect.
//  Write DATA (qualified): if count<TX_DEPTH push IO_write_data at wr_ptr, wr_ptr wraps mod TX_DEPTH; if full byte dropped silently.
//   Writes to any other port ignored.
//  TX handshake: tx_valid = (count!=0); tx_data = FIFO head. Transfer when tx_valid&tx_ready -> rd_ptr+1 mod TX_DEPTH.
//   tx_data stable while tx_valid=1 and tx_ready=0. Empty: tx_valid=0, tx_data holds last value.
//  Simultaneous push+pop: count unchanged; full test uses pre-cycle count (push when full is dropped even if pop same cycle).
//  Push into empty FIFO: tx_valid high next cycle (1-cycle latency).
//  RX: rx_valid with holding empty -> capture rx_data, present=1 next cycle.
//   rx_valid with holding full -> new byte dropped (old kept); qualified read of DATA clears present.
//   rx_valid same cycle as qualified DATA read: processor sees old byte, new byte captured, present stays 1.
//  Reset mid-transfer: FIFO contents discarded, tx_valid drops asynchronously; UART must tolerate abandoned valid.
// CONFIGURATION
//  IO_RX_OVERRUN_EN defined: sticky overrun bit set when rx_valid arrives with holding full; PORT_OVR reads
//   8'hFF if set else 8'h00; qualified read of PORT_OVR clears it (set wins if same cycle).
//  Undefined: no overrun register; PORT_OVR reads 8'hFF like any unmapped port; dropped bytes not reported.
// TESTING
//  Reset then read 02/03/01 -> 8'h00, 8'h00, 8'h00; tx_valid=0.
//  Write 8'hA5 to 01, tx_ready=1 -> tx_valid next cycle with tx_data=A5, one transfer, then tx_valid=0.
//  tx_ready=0, write 9 bytes 00..08 (TX_DEPTH=8) -> port 03 reads FF after 8th; 08 dropped; release -> 00..07 in order.
//  Hold IO_write_strobe 4 cycles on 01 with 8'h3C -> exactly one push (count=1).
//  rx_valid 8'h5A, then rx_valid 8'h77 -> 02=FF, 01 reads 5A, 02=00; with IO_RX_OVERRUN_EN 04=FF then 00 on reread.
//  rx_valid 8'h11 coincident with read of 01 holding 8'h22 -> read returns 22, next read returns 11.

Source files
------------

// File: rtl/io_uart_port_ctrl_if.sv
// Bus bundle between the processor IO port / UART cores and io_uart_port_ctrl.
// master = processor and UART side, slave = the port controller.
interface io_uart_port_ctrl_if;
  logic [7:0] IO_port_ID;
  logic [7:0] IO_write_data;
  logic       IO_write_strobe;
  logic       IO_read_strobe;
  logic [7:0] IO_read_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (
    output IO_port_ID,
    output IO_write_data,
    output IO_write_strobe,
    output IO_read_strobe,
    input  IO_read_data,
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );

  modport slave (
    input  IO_port_ID,
    input  IO_write_data,
    input  IO_write_strobe,
    input  IO_read_strobe,
    output IO_read_data,
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );
endinterface

// File: rtl/io_uart_port_ctrl.sv
// Processor IO port controller: TX FIFO toward the UART transmitter, one-byte RX holding register.
// Optional feature macro: IO_RX_OVERRUN_EN (sticky RX overrun flag readable on PORT_OVR).
module io_uart_port_ctrl #(
  parameter int         TX_DEPTH    = 8,
  parameter logic [7:0] PORT_DATA   = 8'h01,
  parameter logic [7:0] PORT_RXSTAT = 8'h02,
  parameter logic [7:0] PORT_TXSTAT = 8'h03,
  parameter logic [7:0] PORT_OVR    = 8'h04
) (
  input logic                clk100,
  input logic                reset_n,
  io_uart_port_ctrl_if.slave io_bus
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(TX_DEPTH);

  logic [7:0]    r_mem [TX_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_tx_last;
  logic          r_wr_stb_prev;
  logic          r_rd_stb_prev;
  logic [7:0]    r_rx_data;
  logic          r_rx_present;

  logic          w_wr_qual;
  logic          w_rd_qual;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_tx_valid;
  logic [7:0]    w_head;
  logic          w_rx_pop;
  logic          w_rx_capture;
  logic [7:0]    w_read_data;

  // A held strobe acts only on its rising cycle.
  assign w_wr_qual = io_bus.IO_write_strobe & ~r_wr_stb_prev;
  assign w_rd_qual = io_bus.IO_read_strobe & ~r_rd_stb_prev;

  assign w_full     = (r_count == FULL_COUNT);
  assign w_tx_valid = (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_push     = w_wr_qual && (io_bus.IO_port_ID == PORT_DATA) && !w_full;
  assign w_pop      = w_tx_valid && io_bus.tx_ready;

  assign w_rx_pop     = w_rd_qual && (io_bus.IO_port_ID == PORT_DATA);
  assign w_rx_capture = io_bus.rx_valid && (!r_rx_present || w_rx_pop);

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_stb_prev <= 1'b0;
      r_rd_stb_prev <= 1'b0;
    end else begin
      r_wr_stb_prev <= io_bus.IO_write_strobe;
      r_rd_stb_prev <= io_bus.IO_read_strobe;
    end
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TX_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= io_bus.IO_write_data;
    end
  end

  // Full test uses the pre-cycle count, so a push while full is dropped even if a pop happens too.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_tx_last <= 8'h00;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_tx_last <= w_head;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign io_bus.tx_valid = w_tx_valid;
  assign io_bus.tx_data  = w_tx_valid ? w_head : r_tx_last;

  // A DATA read in the same cycle as rx_valid frees the slot, so the new byte is taken.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_data    <= 8'h00;
      r_rx_present <= 1'b0;
    end else if (w_rx_capture) begin
      r_rx_data    <= io_bus.rx_data;
      r_rx_present <= 1'b1;
    end else if (w_rx_pop) begin
      r_rx_present <= 1'b0;
    end
  end

`ifdef IO_RX_OVERRUN_EN
  logic r_overrun;
  logic w_ovr_clear;

  assign w_ovr_clear = w_rd_qual && (io_bus.IO_port_ID == PORT_OVR);

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (io_bus.rx_valid && !w_rx_capture) begin
      r_overrun <= 1'b1;
    end else if (w_ovr_clear) begin
      r_overrun <= 1'b0;
    end
  end
`endif

  always_comb begin
    w_read_data = 8'hFF;
    case (io_bus.IO_port_ID)
      PORT_DATA:   w_read_data = r_rx_data;
      PORT_RXSTAT: w_read_data = r_rx_present ? 8'hFF : 8'h00;
      PORT_TXSTAT: w_read_data = w_full ? 8'hFF : 8'h00;
`ifdef IO_RX_OVERRUN_EN
      PORT_OVR:    w_read_data = r_overrun ? 8'hFF : 8'h00;
`else
      PORT_OVR:    w_read_data = 8'hFF;
`endif
      default:     w_read_data = 8'hFF;
    endcase
  end

  assign io_bus.IO_read_data = w_read_data;

endmodule

// File: tb/tb_io_uart_port_ctrl.sv
// Directed bench for io_uart_port_ctrl; TX bytes are checked against a scoreboard queue.
// Build with IO_RX_OVERRUN_EN defined to exercise the overrun port expectations.
module tb_io_uart_port_ctrl;
  localparam int TX_DEPTH = 8;

  logic clk100;
  logic reset_n;
  int   assertCount;
  int   failCount;
  logic [7:0] txQueue [$];

  io_uart_port_ctrl_if busIf ();

  io_uart_port_ctrl #(.TX_DEPTH(TX_DEPTH)) dut (
    .clk100  (clk100),
    .reset_n (reset_n),
    .io_bus  (busIf.slave)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] port, input logic [7:0] data);
    @(negedge clk100);
    busIf.IO_port_ID      = port;
    busIf.IO_write_data   = data;
    busIf.IO_write_strobe = 1'b1;
    if (port == 8'h01 && txQueue.size() < TX_DEPTH) txQueue.push_back(data);
    @(negedge clk100);
    busIf.IO_write_strobe = 1'b0;
  endtask

  task automatic ioRead(input logic [7:0] port, input logic [7:0] expected, input string tag);
    @(negedge clk100);
    busIf.IO_port_ID     = port;
    busIf.IO_read_strobe = 1'b1;
    #1;
    checkOutput(tag, busIf.IO_read_data, expected);
    @(negedge clk100);
    busIf.IO_read_strobe = 1'b0;
  endtask

  task automatic rxPulse(input logic [7:0] data);
    @(negedge clk100);
    busIf.rx_data  = data;
    busIf.rx_valid = 1'b1;
    @(negedge clk100);
    busIf.rx_valid = 1'b0;
  endtask

  task automatic drainTx(input string tag);
    int budget;
    budget = 40;
    @(negedge clk100);
    busIf.tx_ready = 1'b1;
    while (txQueue.size() != 0 && budget > 0) begin
      @(negedge clk100);
      budget--;
    end
    repeat (2) @(negedge clk100);
    #1;
    checkOutput({tag, "_left"}, 8'(txQueue.size()), 8'd0);
    checkOutput({tag, "_valid_low"}, {7'd0, busIf.tx_valid}, 8'd0);
  endtask

  // Every accepted transfer must match the oldest byte the model queued.
  always @(negedge clk100) begin
    #2;
    if (busIf.tx_valid === 1'b1 && busIf.tx_ready === 1'b1) begin
      if (txQueue.size() == 0) begin
        checkOutput("tx_unexpected_xfer", busIf.tx_data, 8'h00 ^ ~busIf.tx_data);
      end else begin
        checkOutput("tx_data", busIf.tx_data, txQueue.pop_front());
      end
    end
  end

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset_n               = 1'b0;
    busIf.IO_port_ID      = 8'h00;
    busIf.IO_write_data   = 8'h00;
    busIf.IO_write_strobe = 1'b0;
    busIf.IO_read_strobe  = 1'b0;
    busIf.tx_ready        = 1'b0;
    busIf.rx_data         = 8'h00;
    busIf.rx_valid        = 1'b0;
    repeat (3) @(negedge clk100);
    reset_n = 1'b1;

    ioRead(8'h02, 8'h00, "reset_rxstat");
    ioRead(8'h03, 8'h00, "reset_txstat");
    ioRead(8'h01, 8'h00, "reset_rxdata");
    checkOutput("reset_tx_valid", {7'd0, busIf.tx_valid}, 8'd0);
    ioRead(8'h07, 8'hFF, "unmapped_port");

    // Single byte with the transmitter ready.
    busIf.tx_ready = 1'b1;
    applyStimulus(8'h01, 8'hA5);
    #1;
    checkOutput("a5_valid", {7'd0, busIf.tx_valid}, 8'd1);
    checkOutput("a5_data", busIf.tx_data, 8'hA5);
    @(negedge clk100);
    #1;
    checkOutput("a5_valid_drop", {7'd0, busIf.tx_valid}, 8'd0);
    checkOutput("a5_data_hold", busIf.tx_data, 8'hA5);
    checkOutput("a5_left", 8'(txQueue.size()), 8'd0);

    // Held write strobe must push exactly once.
    busIf.tx_ready = 1'b0;
    @(negedge clk100);
    busIf.IO_port_ID      = 8'h01;
    busIf.IO_write_data   = 8'h3C;
    busIf.IO_write_strobe = 1'b1;
    txQueue.push_back(8'h3C);
    repeat (4) @(negedge clk100);
    busIf.IO_write_strobe = 1'b0;
    #1;
    checkOutput("hold_valid", {7'd0, busIf.tx_valid}, 8'd1);
    drainTx("hold");

    // Fill past capacity; the ninth byte is dropped.
    busIf.tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'h01, 8'(i));
      if (i == 6) ioRead(8'h03, 8'h00, "txstat_7");
      if (i == 7) ioRead(8'h03, 8'hFF, "txstat_full");
    end
    ioRead(8'h03, 8'hFF, "txstat_after_drop");
    #1;
    checkOutput("full_head_stable", busIf.tx_data, 8'h00);
    drainTx("full");
    ioRead(8'h03, 8'h00, "txstat_drained");

    // Reset while a byte is pending abandons it immediately.
    busIf.tx_ready = 1'b0;
    applyStimulus(8'h01, 8'hC3);
    #1;
    checkOutput("mid_valid", {7'd0, busIf.tx_valid}, 8'd1);
    @(negedge clk100);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_reset_valid", {7'd0, busIf.tx_valid}, 8'd0);
    checkOutput("mid_reset_data", busIf.tx_data, 8'h00);
    txQueue.delete();
    @(negedge clk100);
    reset_n = 1'b1;

    // Second byte while holding is full gets dropped.
    rxPulse(8'h5A);
    rxPulse(8'h77);
    ioRead(8'h02, 8'hFF, "rx_present");
`ifdef IO_RX_OVERRUN_EN
    ioRead(8'h04, 8'hFF, "ovr_set");
    ioRead(8'h04, 8'h00, "ovr_cleared");
`else
    ioRead(8'h04, 8'hFF, "ovr_unmapped");
    ioRead(8'h04, 8'hFF, "ovr_unmapped_again");
`endif
    ioRead(8'h01, 8'h5A, "rx_old_kept");
    ioRead(8'h02, 8'h00, "rx_cleared");

    // rx_valid coincident with a DATA read.
    rxPulse(8'h22);
    @(negedge clk100);
    busIf.rx_data        = 8'h11;
    busIf.rx_valid       = 1'b1;
    busIf.IO_port_ID     = 8'h01;
    busIf.IO_read_strobe = 1'b1;
    #1;
    checkOutput("coinc_old", busIf.IO_read_data, 8'h22);
    @(negedge clk100);
    busIf.rx_valid       = 1'b0;
    busIf.IO_read_strobe = 1'b0;
    ioRead(8'h02, 8'hFF, "coinc_present");
    ioRead(8'h01, 8'h11, "coinc_new");
    ioRead(8'h02, 8'h00, "coinc_empty");

    repeat (2) @(negedge clk100);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
